// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: PC/IR registers, registered RAM address, request/valid handshake.
// Optional fetch breakpoint (HALT state, bp_* ports, halted) enabled by defining FETCH_BREAKPOINT_EN.
module instr_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MEM_LAT  = 1,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fetch_req,
    input  logic              pc_rst,
    input  logic              pc_wen,
    input  logic              pc_inc,
    input  logic [ADDR_W-1:0] pc_din,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ins,
    output logic              ins_valid,
    output logic              busy
`ifdef FETCH_BREAKPOINT_EN
   ,input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_arm,
    input  logic              bp_resume,
    output logic              halted
`endif
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
    logic [DATA_W-1:0] ins_q, ins_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              vld_q, vld_d, busy_q, busy_d;
    logic              issue, bp_hit, bp_go;

`ifdef FETCH_BREAKPOINT_EN
    assign bp_hit = bp_arm && (pc_q == bp_addr);
    assign bp_go  = bp_resume;
    assign halted = (state_q == S_HALT);
`else
    assign bp_hit = 1'b0;
    assign bp_go  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ins_d   = ins_q;
        cnt_d   = cnt_q;
        vld_d   = 1'b0;
        busy_d  = busy_q;
        issue   = 1'b0;

        if (pc_rst)      pc_d = PC_INIT;
        else if (pc_wen) pc_d = pc_din;
        else if (pc_inc) pc_d = pc_q + ADDR_W'(1);

        case (state_q)
            S_IDLE: begin
                if (fetch_req) begin
                    if (bp_hit) state_d = S_HALT;
                    else        issue   = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    ins_d   = mem_q;
                    vld_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            // resume bypasses the breakpoint check for this one fetch
            S_HALT:  if (bp_go) issue = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // address latched from the PC before any same-edge PC update
        if (issue) begin
            addr_d  = pc_q;
            cnt_d   = CNT_W'(MEM_LAT);
            busy_d  = 1'b1;
            state_d = S_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= PC_INIT;
            addr_q  <= PC_INIT;
            ins_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ins_q   <= ins_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
        end else begin
            vld_q <= 1'b0;
        end
    end

    assign mem_addr  = addr_q;
    assign pc        = pc_q;
    assign ins       = ins_q;
    assign ins_valid = vld_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench: lane 0 runs MEM_LAT=1, lane 1 runs MEM_LAT=3; RAM word = addr ^ 8'hA5.
// Breakpoint scenario compiled only with FETCH_BREAKPOINT_EN.
module tb_instr_fetch_unit;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      en, fetch_req, pc_rst, pc_wen, pc_inc, ins_valid, busy;
    logic [1:0][7:0] pc_din, mem_q, mem_addr, pc, ins;
`ifdef FETCH_BREAKPOINT_EN
    logic [1:0][7:0] bp_addr;
    logic [1:0]      bp_arm, bp_resume, halted;
`endif

    exp_t sb_q[2][$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   run = 1'b0;
    bit   rst_q = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_q <= rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int g, input logic [7:0] d, input int at);
        exp_t e;
        e.data = d;
        e.cyc  = at;
        sb_q[g].push_back(e);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [7:0] pipe [LAT];
        logic [7:0] exp_ins = 8'h00;

        instr_fetch_unit #(
            .ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT), .RESET_PC(0)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .en        (en[g]),
            .fetch_req (fetch_req[g]),
            .pc_rst    (pc_rst[g]),
            .pc_wen    (pc_wen[g]),
            .pc_inc    (pc_inc[g]),
            .pc_din    (pc_din[g]),
            .mem_q     (mem_q[g]),
            .mem_addr  (mem_addr[g]),
            .pc        (pc[g]),
            .ins       (ins[g]),
            .ins_valid (ins_valid[g]),
`ifdef FETCH_BREAKPOINT_EN
            .bp_addr   (bp_addr[g]),
            .bp_arm    (bp_arm[g]),
            .bp_resume (bp_resume[g]),
            .halted    (halted[g]),
`endif
            .busy      (busy[g])
        );

        // RAM with LAT-edge read latency from the registered address
        always @(posedge clk) begin
            pipe[0] <= mem_addr[g] ^ 8'hA5;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_q[g] = pipe[LAT-1];

        always @(negedge clk) begin
            if (run) begin
                if (ins_valid[g]) begin
                    if (sb_q[g].size() == 0) begin
                        check($sformatf("lane%0d spurious ins_valid", g), {31'd0, ins_valid[g]}, 32'd0);
                    end else begin
                        check($sformatf("lane%0d ins data", g), {24'd0, ins[g]}, {24'd0, sb_q[g][0].data});
                        check($sformatf("lane%0d ins_valid cycle", g), cyc, sb_q[g][0].cyc);
                        exp_ins <= sb_q[g][0].data;
                        sb_q[g].delete(0);
                    end
                end else begin
                    check($sformatf("lane%0d ins hold", g), {24'd0, ins[g]},
                          {24'd0, (rst_q ? 8'h00 : exp_ins)});
                    if (rst_q) exp_ins <= 8'h00;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        en = 2'b11; fetch_req = '0; pc_rst = '0; pc_wen = '0; pc_inc = '0; pc_din = '0;
`ifdef FETCH_BREAKPOINT_EN
        bp_addr = '0; bp_arm = '0; bp_resume = '0;
`endif
        rst = 1'b1;
        tick();
        for (int g = 0; g < 2; g++) begin
            check("reset pc", {24'd0, pc[g]}, 32'h00);
            check("reset mem_addr", {24'd0, mem_addr[g]}, 32'h00);
            check("reset ins", {24'd0, ins[g]}, 32'h00);
            check("reset ins_valid", {31'd0, ins_valid[g]}, 32'd0);
            check("reset busy", {31'd0, busy[g]}, 32'd0);
`ifdef FETCH_BREAKPOINT_EN
            check("reset halted", {31'd0, halted[g]}, 32'd0);
`endif
        end
        rst = 1'b0;
        run = 1'b1;

        // single fetch at pc 0, MEM_LAT=1
        c = cyc;
        fetch_req[0] = 1'b1;
        push(0, 8'hA5, c + 3);
        tick();
        fetch_req[0] = 1'b0;
        check("busy after accept", {31'd0, busy[0]}, 32'd1);
        tick();
        check("busy mid wait", {31'd0, busy[0]}, 32'd1);
        tick();
        check("busy after deliver", {31'd0, busy[0]}, 32'd0);
        tick();

        // PC wrap and priority
        pc_wen[0] = 1'b1; pc_din[0] = 8'hFF;
        tick();
        check("pc load FF", {24'd0, pc[0]}, 32'hFF);
        pc_wen[0] = 1'b0; pc_inc[0] = 1'b1;
        tick();
        check("pc wrap", {24'd0, pc[0]}, 32'h00);
        pc_wen[0] = 1'b1; pc_din[0] = 8'h10;
        tick();
        check("pc_wen over pc_inc", {24'd0, pc[0]}, 32'h10);
        pc_rst[0] = 1'b1; pc_din[0] = 8'h40;
        tick();
        check("pc_rst priority", {24'd0, pc[0]}, 32'h00);
        pc_rst[0] = 1'b0; pc_inc[0] = 1'b0; pc_din[0] = 8'h01;
        tick();
        pc_wen[0] = 1'b0;

        // jump during WAIT: in-flight fetch keeps old address
        c = cyc;
        fetch_req[0] = 1'b1;
        push(0, 8'hA4, c + 3);
        tick();
        fetch_req[0] = 1'b0;
        pc_wen[0] = 1'b1; pc_din[0] = 8'h20;
        tick();
        pc_wen[0] = 1'b0;
        check("pc jump in wait", {24'd0, pc[0]}, 32'h20);
        check("mem_addr held in wait", {24'd0, mem_addr[0]}, 32'h01);
        tick();

        // fetch with same-edge pc_inc; request held into WAIT is dropped
        c = cyc;
        fetch_req[0] = 1'b1; pc_inc[0] = 1'b1;
        push(0, 8'h85, c + 3);
        tick();
        pc_inc[0] = 1'b0;
        check("mem_addr pre-increment pc", {24'd0, mem_addr[0]}, 32'h20);
        check("pc post-increment", {24'd0, pc[0]}, 32'h21);
        tick();
        fetch_req[0] = 1'b0;
        tick();
        tick(); tick();

        // reset mid-fetch aborts it
        fetch_req[0] = 1'b1;
        tick();
        fetch_req[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort pc", {24'd0, pc[0]}, 32'h00);
        check("abort busy", {31'd0, busy[0]}, 32'd0);
        check("abort mem_addr", {24'd0, mem_addr[0]}, 32'h00);
        tick(); tick(); tick();

        // MEM_LAT=3 back-to-back with en stall on the second fetch
        pc_wen[1] = 1'b1; pc_din[1] = 8'h02;
        tick();
        pc_wen[1] = 1'b0;
        c = cyc;
        fetch_req[1] = 1'b1;
        push(1, 8'hA7, c + 5);
        push(1, 8'hA2, c + 12);
        push(1, 8'hA2, c + 17);
        while (cyc < c + 17) begin
            tick();
            if (cyc == c + 1) begin pc_wen[1] = 1'b1; pc_din[1] = 8'h07; end
            if (cyc == c + 2) pc_wen[1] = 1'b0;
            if (cyc == c + 7) en[1] = 1'b0;
            if (cyc == c + 8) pc_inc[1] = 1'b1;
            if (cyc == c + 9) begin
                check("en=0 freezes pc", {24'd0, pc[1]}, 32'h07);
                check("en=0 keeps busy", {31'd0, busy[1]}, 32'd1);
                pc_inc[1] = 1'b0;
                en[1] = 1'b1;
            end
        end
        fetch_req[1] = 1'b0;
        tick(); tick();

`ifdef FETCH_BREAKPOINT_EN
        pc_wen[0] = 1'b1; pc_din[0] = 8'h03;
        tick();
        pc_wen[0] = 1'b0;
        bp_addr[0] = 8'h03; bp_arm[0] = 1'b1; fetch_req[0] = 1'b1;
        tick();
        fetch_req[0] = 1'b0;
        check("bp halted", {31'd0, halted[0]}, 32'd1);
        check("bp no busy", {31'd0, busy[0]}, 32'd0);
        check("bp mem_addr unchanged", {24'd0, mem_addr[0]}, 32'h00);
        tick();
        fetch_req[0] = 1'b1;
        tick();
        fetch_req[0] = 1'b0;
        check("halt ignores fetch_req", {31'd0, halted[0]}, 32'd1);
        c = cyc;
        bp_resume[0] = 1'b1;
        push(0, 8'hA6, c + 3);
        tick();
        bp_resume[0] = 1'b0;
        check("resume clears halted", {31'd0, halted[0]}, 32'd0);
        check("resume busy", {31'd0, busy[0]}, 32'd1);
        check("resume mem_addr", {24'd0, mem_addr[0]}, 32'h03);
        tick(); tick(); tick();
        bp_arm[0] = 1'b0;
`endif

        tick(); tick(); tick();
        check("lane0 scoreboard drained", sb_q[0].size(), 32'd0);
        check("lane1 scoreboard drained", sb_q[1].size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
